// File: rtl/display_scan_ctrl.sv
// Multiplexed 7-segment scan controller: double-buffered digits, per-digit
// enable slots with an all-off guard gap, and leading-zero / invalid-code blanking.
module display_scan_ctrl #(
  parameter int N_DIGITS     = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int GUARD_CYCLES = 500
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] digits_in,
  input  logic                  blank_lz,
  input  logic [6:0]            seg_in,
  output logic [3:0]            bcd_out,
  output logic [N_DIGITS-1:0]   an_out,
  output logic [6:0]            seg_out,
  output logic                  frame_done
);
  localparam int DW       = 4 * N_DIGITS;
  localparam int TICK_MAX = ((REFRESH_DIV > GUARD_CYCLES) ? REFRESH_DIV : GUARD_CYCLES) - 1;
  localparam int TICK_W   = (TICK_MAX < 1) ? 1 : $clog2(TICK_MAX + 1);
  localparam int IDX_W    = (N_DIGITS < 2) ? 1 : $clog2(N_DIGITS);

  localparam logic [TICK_W-1:0] SHOW_LAST  = TICK_W'(REFRESH_DIV - 1);
  localparam logic [TICK_W-1:0] GUARD_LAST = TICK_W'(GUARD_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(N_DIGITS - 1);

  typedef enum logic [1:0] {OFF, SHOW, GUARD} state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [TICK_W-1:0] tick, tick_nxt;
  logic              enter_show, boundary, transfer, fd_nxt;
  logic [DW-1:0]     shadow, active, active_nxt;
  logic              pending, blank;
  logic [3:0]        nib_sel;

  // Codes above 9 cannot be shown; they are forced to 0 and blanked.
  function automatic logic [3:0] sat_bcd(input logic [3:0] nib);
    sat_bcd = (nib > 4'd9) ? 4'h0 : nib;
  endfunction

  function automatic logic upper_zero(input logic [DW-1:0] v, input logic [IDX_W-1:0] i);
    upper_zero = 1'b1;
    for (int j = 0; j < N_DIGITS; j++)
      if (j >= int'(i) && v[4*j +: 4] != 4'h0) upper_zero = 1'b0;
  endfunction

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    tick_nxt   = tick;
    enter_show = 1'b0;
    boundary   = 1'b0;
    case (state)
      OFF: begin
        state_nxt  = SHOW;
        idx_nxt    = '0;
        tick_nxt   = '0;
        enter_show = 1'b1;
      end
      SHOW: begin
        if (tick == SHOW_LAST) begin
          state_nxt = GUARD;
          tick_nxt  = '0;
        end else begin
          tick_nxt = tick + TICK_W'(1);
        end
      end
      GUARD: begin
        if (tick == GUARD_LAST) begin
          state_nxt  = SHOW;
          tick_nxt   = '0;
          enter_show = 1'b1;
          if (idx == IDX_LAST) begin
            idx_nxt  = '0;
            boundary = 1'b1;
          end else begin
            idx_nxt = idx + IDX_W'(1);
          end
        end else begin
          tick_nxt = tick + TICK_W'(1);
        end
      end
      default: state_nxt = OFF;
    endcase
    if (!en) begin
      state_nxt  = OFF;
      idx_nxt    = '0;
      tick_nxt   = '0;
      enter_show = 1'b0;
      boundary   = 1'b0;
    end
    fd_nxt     = (state_nxt == GUARD) && (idx_nxt == IDX_LAST) && (tick_nxt == GUARD_LAST);
    // Shadow becomes visible only at a frame boundary or when the scan starts.
    transfer   = pending && (boundary || (state == OFF && en));
    active_nxt = transfer ? shadow : active;
    nib_sel    = active_nxt[4*idx_nxt +: 4];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= OFF;
      idx        <= '0;
      tick       <= '0;
      an_out     <= '0;
      bcd_out    <= 4'h0;
      blank      <= 1'b1;
      frame_done <= 1'b0;
      shadow     <= '0;
      active     <= '0;
      pending    <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      tick       <= tick_nxt;
      frame_done <= fd_nxt;
      active     <= active_nxt;
      if (load) begin
        shadow  <= digits_in;
        pending <= 1'b1;
      end else if (transfer) begin
        pending <= 1'b0;
      end
      if (enter_show) begin
        an_out  <= N_DIGITS'(1) << idx_nxt;
        bcd_out <= sat_bcd(nib_sel);
        blank   <= (nib_sel > 4'd9) ||
                   (blank_lz && idx_nxt != '0 && upper_zero(active_nxt, idx_nxt));
      end else if (state_nxt != SHOW) begin
        an_out <= '0;
      end
    end
  end

  assign seg_out = (blank || an_out == '0) ? 7'b0 : seg_in;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl: directed scenarios with literal
// expectations plus a randomized run, all checked against a time-based model.
module tb_display_scan_ctrl;
  localparam int N     = 4;
  localparam int RD    = 4;
  localparam int GC    = 1;
  localparam int P     = RD + GC;
  localparam int FRAME = N * P;

  logic         clk;
  logic         rst_n, en, load, blank_lz;
  logic [15:0]  digits_in;
  logic [6:0]   seg_in, seg_out, noise;
  logic [3:0]   bcd_out;
  logic [N-1:0] an_out;
  logic         frame_done;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 0;

  // Model state: the scan is described by elapsed cycles since it started.
  bit          running = 0;
  int          t = 0;
  logic [15:0] m_shadow = '0, m_active = '0;
  bit          m_pending = 0;
  logic [3:0]  exp_bcd = '0;
  bit          exp_blank = 1;

  display_scan_ctrl #(.N_DIGITS(N), .REFRESH_DIV(RD), .GUARD_CYCLES(GC)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .digits_in(digits_in),
    .blank_lz(blank_lz), .seg_in(seg_in), .bcd_out(bcd_out), .an_out(an_out),
    .seg_out(seg_out), .frame_done(frame_done)
  );

  function automatic logic [6:0] seg7(input logic [3:0] b);
    case (b)
      4'd0: seg7 = 7'h3F; 4'd1: seg7 = 7'h06; 4'd2: seg7 = 7'h5B; 4'd3: seg7 = 7'h4F;
      4'd4: seg7 = 7'h66; 4'd5: seg7 = 7'h6D; 4'd6: seg7 = 7'h7D; 4'd7: seg7 = 7'h07;
      4'd8: seg7 = 7'h7F; 4'd9: seg7 = 7'h6F; default: seg7 = 7'h79;
    endcase
  endfunction

  assign seg_in = seg7(bcd_out) ^ noise;

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        running = 0; t = 0; m_shadow = '0; m_active = '0; m_pending = 0;
        exp_bcd = '0; exp_blank = 1;
      end else begin
        bit boundary, start;
        int d;
        logic [3:0] nib;
        boundary = running && en && (t == FRAME - 1);
        start    = !running && en;
        if (m_pending && (boundary || start)) begin
          m_active = m_shadow; m_pending = 0;
        end
        if (load) begin
          m_shadow = digits_in; m_pending = 1;
        end
        if (!en) begin running = 0; t = 0; end
        else if (!running) begin running = 1; t = 0; end
        else t = (t + 1) % FRAME;
        if (running && (t % P) == 0) begin
          d   = t / P;
          nib = m_active[4*d +: 4];
          exp_bcd   = (nib > 9) ? 4'd0 : nib;
          exp_blank = (nib > 9) || (blank_lz && d != 0 && ((m_active >> (4*d)) == 16'd0));
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        logic [N-1:0] e_an;
        logic [6:0]   e_seg;
        e_an  = (running && (t % P) < RD) ? N'(1) << (t / P) : '0;
        e_seg = (e_an != '0 && !exp_blank) ? (seg7(exp_bcd) ^ noise) : 7'd0;
        check("model_an", 32'(an_out), 32'(e_an));
        check("model_frame_done", 32'(frame_done), 32'(running && t == FRAME - 1));
        check("model_bcd", 32'(bcd_out), 32'(exp_bcd));
        check("model_seg", 32'(seg_out), 32'(e_seg));
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic wait_fd();
    bit seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      cyc();
      if (frame_done === 1'b1) seen = 1;
    end
    check("wait_frame_done", 32'(seen), 32'd1);
  endtask

  task automatic do_load(input logic [15:0] v);
    load = 1; digits_in = v;
    cyc();
    load = 0;
  endtask

  initial begin
    int fd_cnt, fd_first;
    logic [3:0] exp_d[4];
    rst_n = 0; en = 1; load = 0; digits_in = '0; blank_lz = 0; noise = '0;

    // 1: reset and first frame
    repeat (3) cyc();
    chk_on = 1;
    check("rst_an", 32'(an_out), 32'd0);
    check("rst_seg", 32'(seg_out), 32'd0);
    check("rst_bcd", 32'(bcd_out), 32'd0);
    rst_n = 1;
    fd_cnt = 0; fd_first = 0;
    for (int i = 1; i <= 40; i++) begin
      cyc();
      if (i == 1) check("first_an_c1", 32'(an_out), 32'b0001);
      if (i == 4) check("first_an_c4", 32'(an_out), 32'b0001);
      if (i == 5) check("first_an_guard", 32'(an_out), 32'b0000);
      if (i == 6) check("first_an_c6", 32'(an_out), 32'b0010);
      if (frame_done) begin
        fd_cnt++;
        if (fd_first == 0) fd_first = i;
      end
    end
    check("fd_first_cycle", 32'(fd_first), 32'd20);
    check("fd_count_40", 32'(fd_cnt), 32'd2);

    // 2: load while off, then scan
    en = 0; cyc();
    do_load(16'h1234);
    en = 1; cyc();
    exp_d = '{4'd4, 4'd3, 4'd2, 4'd1};
    for (int d = 0; d < 4; d++) begin
      check("scan_an", 32'(an_out), 32'(1 << d));
      check("scan_bcd", 32'(bcd_out), 32'(exp_d[d]));
      check("scan_seg", 32'(seg_out), 32'(seg7(exp_d[d])));
      if (d < 3) repeat (P) cyc();
    end

    // 3: tear-free update, last load wins
    do_load(16'h0059);
    do_load(16'h0100);
    wait_fd(); cyc();
    exp_d = '{4'd0, 4'd0, 4'd1, 4'd0};
    for (int d = 0; d < 4; d++) begin
      check("tear_bcd", 32'(bcd_out), 32'(exp_d[d]));
      if (d < 3) repeat (P) cyc();
    end

    // 4: leading-zero and invalid blanking
    blank_lz = 1;
    do_load(16'h0007);
    wait_fd(); cyc();
    for (int d = 0; d < 4; d++) begin
      check("lz_an", 32'(an_out), 32'(1 << d));
      check("lz_seg", 32'(seg_out), (d == 0) ? 32'h07 : 32'h00);
      if (d < 3) repeat (P) cyc();
    end
    do_load(16'h00A5);
    wait_fd(); cyc();
    check("inv_d0_seg", 32'(seg_out), 32'h6D);
    repeat (P) cyc();
    check("inv_d1_an", 32'(an_out), 32'b0010);
    check("inv_d1_bcd", 32'(bcd_out), 32'd0);
    check("inv_d1_seg", 32'(seg_out), 32'd0);
    do_load(16'h0000);
    wait_fd(); cyc();
    check("zero_d0_seg", 32'(seg_out), 32'h3F);
    repeat (P) cyc();
    check("zero_d1_seg", 32'(seg_out), 32'd0);

    // 5: enable drop and reset mid-operation
    wait_fd(); cyc();
    repeat (10) cyc();
    check("en_d2_an", 32'(an_out), 32'b0100);
    en = 0; cyc();
    check("en_off_an", 32'(an_out), 32'd0);
    fd_cnt = 0;
    for (int i = 0; i < 25; i++) begin
      if (frame_done) fd_cnt++;
      cyc();
    end
    check("en_off_no_fd", 32'(fd_cnt), 32'd0);
    en = 1; cyc();
    check("en_restart_an", 32'(an_out), 32'b0001);
    repeat (4) cyc();
    check("guard_an", 32'(an_out), 32'd0);
    rst_n = 0; load = 1; digits_in = 16'h1111;
    cyc();
    load = 0;
    check("midrst_an", 32'(an_out), 32'd0);
    check("midrst_bcd", 32'(bcd_out), 32'd0);
    check("midrst_seg", 32'(seg_out), 32'd0);
    check("midrst_fd", 32'(frame_done), 32'd0);
    rst_n = 1;
    cyc(); cyc();
    check("post_rst_an", 32'(an_out), 32'b0001);
    check("post_rst_bcd", 32'(bcd_out), 32'd0);
    check("post_rst_seg", 32'(seg_out), 32'h3F);

    // 6: load coinciding with the frame boundary
    blank_lz = 0;
    do_load(16'h4321);
    wait_fd();
    do_load(16'h9999);
    check("coinc_d0_prior", 32'(bcd_out), 32'd1);
    repeat (3 * P) cyc();
    check("coinc_d3_prior", 32'(bcd_out), 32'd4);
    wait_fd(); cyc();
    check("coinc_next_d0", 32'(bcd_out), 32'd9);

    // randomized run
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 499) != 0);
      if ($urandom_range(0, 99) == 0) en = ~en;
      if ($urandom_range(0, 49) == 0) blank_lz = ~blank_lz;
      load = ($urandom_range(0, 11) == 0);
      for (int k = 0; k < 4; k++)
        digits_in[4*k +: 4] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 11));
      noise = 7'($urandom_range(0, 127));
      cyc();
    end
    load = 0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
